// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
//
// AXI4-Lite slave register file. Terminates the AW, W, B, AR and R channels,
// holds NUM_REGS 32-bit registers, applies byte-strobed writes and exposes
// every register to fabric logic through reg_out.
//
// Parameters:
//   NUM_REGS   number of 32-bit registers (power of two, 2..16)
//   BASE_ADDR  byte address of register 0 (aligned to NUM_REGS*4)
//
// Ports:
//   ACLK, ARESETn              clock (rising edge), synchronous active-low reset
//   AWVALID/AWREADY/AWADDR/AWPROT   write address channel (AWPROT ignored)
//   WVALID/WREADY/WDATA/WSTRB       write data channel
//   BVALID/BREADY/BRESP             write response channel
//   ARVALID/ARREADY/ARADDR/ARPROT   read address channel (ARPROT ignored)
//   RVALID/RREADY/RDATA/RRESP       read data channel
//   reg_out                         flat register contents, reg i at [32i+31:32i]
//
// Configuration macro:
//   AXIL_SLAVE_ERR_EN  when defined, out-of-range accesses answer SLVERR,
//                      writes are dropped and reads return zero. When
//                      undefined, addresses alias through the index bits and
//                      every response is OKAY.
// ---------------------------------------------------------------------------
module axi_lite_slave_regs #(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1111_1100
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [31:0]              ARADDR,
    input  logic [2:0]               ARPROT,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [NUM_REGS*32-1:0]   reg_out
);

    localparam int unsigned IDX_W       = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN        = 32'(NUM_REGS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    wr_state_t        wr_state;
    wr_state_t        wr_state_next;
    rd_state_t        rd_state;
    rd_state_t        rd_state_next;
    logic             aw_full;
    logic             aw_full_next;
    logic             w_full;
    logic             w_full_next;
    logic [31:0]      aw_addr;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic [31:0]      regs [NUM_REGS];
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic [31:0]      wr_offset;
    logic [31:0]      rd_offset;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             unused_bits;

    // Handshakes and ready outputs. Readies are forced low during reset so
    // the master cannot complete a handshake that the reset would discard.
    assign BVALID  = (wr_state == WR_RESP);
    assign RVALID  = (rd_state == RD_RESP);
    assign AWREADY = ARESETn & ~aw_full & ~BVALID;
    assign WREADY  = ARESETn & ~w_full & ~BVALID;
    assign ARREADY = ARESETn & ~RVALID;
    assign aw_hs   = AWVALID & AWREADY;
    assign w_hs    = WVALID & WREADY;
    assign ar_hs   = ARVALID & ARREADY;

    // Address decode: offset from the base, word index from the low offset
    // bits. The byte-lane bits [1:0] are ignored.
    assign wr_offset = aw_addr - BASE_ADDR;
    assign rd_offset = ARADDR - BASE_ADDR;
    assign wr_idx    = wr_offset[IDX_W+1:2];
    assign rd_idx    = rd_offset[IDX_W+1:2];

`ifdef AXIL_SLAVE_ERR_EN
    assign wr_in_range = (wr_offset < SPAN);
    assign rd_in_range = (rd_offset < SPAN);
`else
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
`endif

    // Protection bits and the offset bits outside the index are deliberately
    // not used; collecting them here keeps that intent explicit.
    assign unused_bits = ^{AWPROT, ARPROT, wr_offset, rd_offset, SPAN};

    // Write-path next state. AW and W are captured independently into their
    // holding flags in any order; once both are full the next cycle performs
    // the write, then the response is held until the master takes it.
    always_comb begin
        wr_state_next = wr_state;
        aw_full_next  = aw_full;
        w_full_next   = w_full;
        unique case (wr_state)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_full_next = 1'b1;
                end
                if (w_hs) begin
                    w_full_next = 1'b1;
                end
                if ((aw_full | aw_hs) && (w_full | w_hs)) begin
                    wr_state_next = WR_EXEC;
                end
            end
            WR_EXEC: begin
                aw_full_next  = 1'b0;
                w_full_next   = 1'b0;
                wr_state_next = WR_RESP;
            end
            WR_RESP: begin
                if (BREADY) begin
                    wr_state_next = WR_IDLE;
                end
            end
            default: begin
                wr_state_next = WR_IDLE;
                aw_full_next  = 1'b0;
                w_full_next   = 1'b0;
            end
        endcase
    end

    // Write-path state register and response. BRESP is decided on the
    // execute edge and stays put for the whole response phase.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_state <= WR_IDLE;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            BRESP    <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_next;
            aw_full  <= aw_full_next;
            w_full   <= w_full_next;
            if (wr_state == WR_EXEC) begin
                BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Holding registers for the captured write address, data and strobes.
    // Their contents only matter while the matching flag is set, so they
    // need no reset.
    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            aw_addr <= AWADDR;
        end
        if (w_hs) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
        end
    end

    // Register file. Only strobed bytes change, and only on the execute edge
    // of an accepted (in-range) write.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if ((wr_state == WR_EXEC) && wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // Flatten the register array for fabric consumers.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs[i];
        end
    end

    // Read-path next state: a response is pending from the AR handshake
    // until the master accepts it.
    always_comb begin
        rd_state_next = rd_state;
        unique case (rd_state)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: begin
                rd_state_next = RD_IDLE;
            end
        endcase
    end

    // Read-path state register and data capture. RDATA is sampled from the
    // register array on the AR handshake edge, so a write landing on that
    // same edge is not visible to this read.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rd_state <= RD_IDLE;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_next;
            if (ar_hs) begin
                RDATA <= rd_in_range ? regs[rd_idx] : 32'h0;
                RRESP <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs
//
// Self-checking bench for axi_lite_slave_regs. A table of write/read vectors
// with hand-derived expectations is applied first, followed by hand-written
// sequences for W-before-AW ordering, response back-pressure, a read racing
// a write, out-of-range addressing and reset in the middle of a transaction.
// Expected responses are queued when a transaction is driven and popped when
// the slave presents the matching B or R beat.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

    localparam int unsigned NUM_REGS = 8;
    localparam logic [31:0] BASE     = 32'h1111_1100;

    logic                   ACLK;
    logic                   ARESETn;
    logic                   AWVALID;
    logic                   AWREADY;
    logic [31:0]            AWADDR;
    logic [2:0]             AWPROT;
    logic                   WVALID;
    logic                   WREADY;
    logic [31:0]            WDATA;
    logic [3:0]             WSTRB;
    logic                   BVALID;
    logic                   BREADY;
    logic [1:0]             BRESP;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [31:0]            ARADDR;
    logic [2:0]             ARPROT;
    logic                   RVALID;
    logic                   RREADY;
    logic [31:0]            RDATA;
    logic [1:0]             RRESP;
    logic [NUM_REGS*32-1:0] reg_out;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] wr_q[$];
    vec_t       vecs[8];
    int         err_cnt = 0;
    int         chk_cnt = 0;

    axi_lite_slave_regs #(
        .NUM_REGS (NUM_REGS),
        .BASE_ADDR(BASE)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .AWADDR (AWADDR),
        .AWPROT (AWPROT),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .BRESP  (BRESP),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .ARADDR (ARADDR),
        .ARPROT (ARPROT),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .reg_out(reg_out)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Guard against a hung handshake that slipped past the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one write. AW and W are offered starting at cycles aw_start and
    // w_start; BREADY is held low for b_delay cycles of BVALID.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int aw_start,
                                 input int w_start, input int b_delay,
                                 input logic [1:0] exp_resp, input int idx,
                                 input logic [31:0] exp_val);
        bit         aw_done;
        bit         w_done;
        bit         aw_fire;
        bit         w_fire;
        int         lat;
        logic [1:0] exp_b;
        aw_done = 1'b0;
        w_done  = 1'b0;
        @(posedge ACLK);
        #1;
        wr_q.push_back(exp_resp);
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        for (int t = 0; t < 40 && !(aw_done && w_done); t++) begin
            AWVALID = !aw_done && (t >= aw_start);
            WVALID  = !w_done && (t >= w_start);
            @(negedge ACLK);
            if (w_done && !aw_done) checkOutput("wready_low_after_w", {63'b0, WREADY}, 64'd0);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK);
            #1;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire) w_done = 1'b1;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        checkOutput("wr_handshakes", {62'b0, aw_done, w_done}, 64'd3);
        lat = 1;
        @(negedge ACLK);
        while (!BVALID && lat < 20) begin
            lat++;
            @(negedge ACLK);
        end
        checkOutput("wr_latency", 64'(lat), 64'd2);
        for (int i = 0; i < b_delay; i++) begin
            @(negedge ACLK);
            checkOutput("bvalid_hold", {61'b0, BVALID, BRESP}, {61'b0, 1'b1, exp_resp});
        end
        BREADY = 1'b1;
        if (wr_q.size() == 0) begin
            checkOutput("wr_sb_underflow", 64'd1, 64'd0);
        end else begin
            exp_b = wr_q.pop_front();
            checkOutput("bresp", {62'b0, BRESP}, {62'b0, exp_b});
        end
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        checkOutput("bvalid_cleared", {63'b0, BVALID}, 64'd0);
        checkOutput("reg_out_word", {32'b0, reg_out[idx*32 +: 32]}, {32'b0, exp_val});
    endtask

    // Drive one read and hold RREADY low for r_delay cycles of RVALID.
    task automatic drive_read(input logic [31:0] addr, input int r_delay,
                              input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit      done;
        bit      fire;
        rd_exp_t e;
        done = 1'b0;
        @(posedge ACLK);
        #1;
        e.data = exp_data;
        e.resp = exp_resp;
        rd_q.push_back(e);
        ARADDR  = addr;
        ARVALID = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge ACLK);
            fire = ARREADY;
            @(posedge ACLK);
            #1;
            done = fire;
        end
        ARVALID = 1'b0;
        checkOutput("rd_handshake", {63'b0, done}, 64'd1);
        @(negedge ACLK);
        checkOutput("rvalid_latency", {63'b0, RVALID}, 64'd1);
        for (int i = 0; i < r_delay; i++) begin
            checkOutput("rdata_hold", {31'b0, RVALID, RDATA}, {31'b0, 1'b1, exp_data});
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        if (rd_q.size() == 0) begin
            checkOutput("rd_sb_underflow", 64'd1, 64'd0);
        end else begin
            e = rd_q.pop_front();
            checkOutput("rdata", {32'b0, RDATA}, {32'b0, e.data});
            checkOutput("rresp", {62'b0, RRESP}, {62'b0, e.resp});
        end
        @(posedge ACLK);
        #1;
        RREADY = 1'b0;
        @(negedge ACLK);
        checkOutput("rvalid_cleared", {63'b0, RVALID}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h1111_1111, 32'hA5A5_5A5A, 4'hF, 4, 32'hA5A5_5A5A};
        vecs[1] = '{1'b0, 32'h1111_1111, 32'h0,         4'h0, 0, 32'hA5A5_5A5A};
        vecs[2] = '{1'b1, 32'h1111_1100, 32'hFFFF_FFFF, 4'hF, 0, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 32'h1111_1100, 32'h1234_5678, 4'h5, 0, 32'hFF34_FF78};
        vecs[4] = '{1'b0, 32'h1111_1100, 32'h0,         4'h0, 0, 32'hFF34_FF78};
        vecs[5] = '{1'b1, 32'h1111_111C, 32'hDEAD_BEEF, 4'hC, 7, 32'hDEAD_0000};
        vecs[6] = '{1'b0, 32'h1111_111E, 32'h0,         4'h0, 0, 32'hDEAD_0000};
        vecs[7] = '{1'b0, 32'h1111_1108, 32'h0,         4'h0, 0, 32'h0000_0000};

        ARESETn = 1'b0;
        AWVALID = 1'b0;
        AWADDR  = '0;
        AWPROT  = 3'b000;
        WVALID  = 1'b0;
        WDATA   = '0;
        WSTRB   = '0;
        BREADY  = 1'b0;
        ARVALID = 1'b0;
        ARADDR  = '0;
        ARPROT  = 3'b000;
        RREADY  = 1'b0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("rst_readies", {61'b0, AWREADY, WREADY, ARREADY}, 64'd0);
        checkOutput("rst_valids", {62'b0, BVALID, RVALID}, 64'd0);
        checkOutput("rst_resp_data", {30'b0, BRESP, RDATA}, 64'd0);
        checkOutput("rst_reg_out", {63'b0, (reg_out == '0)}, 64'd1);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("post_rst_readies", {61'b0, AWREADY, WREADY, ARREADY}, 64'd7);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr)
                applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0,
                              2'b00, vecs[i].idx, vecs[i].exp);
            else
                drive_read(vecs[i].addr, 0, vecs[i].exp, 2'b00);
        end

        $display("[TB] W two cycles before AW, BREADY held low");
        applyStimulus(32'h1111_1108, 32'h0BAD_F00D, 4'hF, 2, 0, 3, 2'b00, 2, 32'h0BAD_F00D);
        checkOutput("reg4_untouched", {32'b0, reg_out[4*32 +: 32]}, {32'b0, 32'hA5A5_5A5A});

        $display("[TB] read held while a write to the same register completes");
        fork
            drive_read(32'h1111_1104, 4, 32'h0000_0000, 2'b00);
            applyStimulus(32'h1111_1104, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b00, 1, 32'h5555_AAAA);
        join
        drive_read(32'h1111_1104, 0, 32'h5555_AAAA, 2'b00);

        $display("[TB] access beyond the register window");
`ifdef AXIL_SLAVE_ERR_EN
        applyStimulus(32'h1111_1140, 32'hCAFE_0001, 4'hF, 0, 0, 0, 2'b10, 0, 32'hFF34_FF78);
        drive_read(32'h1111_1140, 0, 32'h0000_0000, 2'b10);
`else
        applyStimulus(32'h1111_1140, 32'hCAFE_0001, 4'hF, 0, 0, 0, 2'b00, 0, 32'hCAFE_0001);
        drive_read(32'h1111_1140, 0, 32'hCAFE_0001, 2'b00);
`endif

        $display("[TB] reset during pending AW and R");
        @(posedge ACLK);
        #1;
        ARADDR  = 32'h1111_1110;
        ARVALID = 1'b1;
        @(negedge ACLK);
        checkOutput("mid_arready", {63'b0, ARREADY}, 64'd1);
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        AWADDR  = 32'h1111_110C;
        AWVALID = 1'b1;
        @(negedge ACLK);
        checkOutput("mid_awready", {63'b0, AWREADY}, 64'd1);
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0;
        @(negedge ACLK);
        checkOutput("mid_pending", {61'b0, RVALID, AWREADY, WREADY}, 64'd5);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        @(negedge ACLK);
        checkOutput("mid_rst_readies", {61'b0, AWREADY, WREADY, ARREADY}, 64'd0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("mid_rst_valids", {62'b0, BVALID, RVALID}, 64'd0);
        checkOutput("mid_rst_regs", {63'b0, (reg_out == '0)}, 64'd1);
        checkOutput("mid_rst_readies_up", {61'b0, AWREADY, WREADY, ARREADY}, 64'd7);
        @(posedge ACLK);
        #1;
        WDATA  = 32'hFFFF_FFFF;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        @(negedge ACLK);
        checkOutput("w_alone_wready", {63'b0, WREADY}, 64'd1);
        @(posedge ACLK);
        #1;
        WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checkOutput("w_alone_no_write", {62'b0, BVALID, (reg_out == '0)}, 64'd1);
        end

        checkOutput("sb_empty", 64'(rd_q.size() + wr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite slave register file that terminates the five channels driven by the team's AXI4-Lite master (write address, write data, write response, read address, read data). It holds NUM_REGS 32-bit registers, applies byte-strobed writes, returns read data with OKAY/SLVERR responses, and exposes all register contents to fabric logic. It sits directly downstream of the master and is the default target on the bus.

## Interface
- NUM_REGS, 8: number of 32-bit registers; power of two, 2..16.
- BASE_ADDR, 32'h1111_1100: byte address of register 0; aligned to NUM_REGS*4.

- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset; synchronous, active-low.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- AWADDR  in  32  write byte address.
- AWPROT  in  3  accepted and ignored.
- WVALID / WREADY  in / out  1  write-data handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; bit i qualifies WDATA[8i+7:8i].
- BVALID / BREADY  out / in  1  write-response handshake.
- BRESP  out  2  write response.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- ARADDR  in  32  read byte address.
- ARPROT  in  3  accepted and ignored.
- RVALID / RREADY  out / in  1  read-data handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- reg_out  out  NUM_REGS*32  flat register contents; reg i at [32i+31:32i].

## Operation
- Decode: offset = addr - BASE_ADDR; index = offset[log2(NUM_REGS)+1:2]; addr[1:0] ignored. Example: 32'h1111_1111 decodes to index 4. In range iff offset < NUM_REGS*4.
- Write path, independent holding flags aw_full and w_full:
  - AWREADY = ARESETn & !aw_full & !BVALID; WREADY = ARESETn & !w_full & !BVALID.
  - Handshake on either channel latches address or data+strobe and sets its flag. Order is free: AW first, W first, or both in the same cycle.
  - Cycle with aw_full & w_full (state WR_EXEC): write performed, flags cleared, BVALID set, BRESP set. Only bytes with WSTRB=1 change.
  - WR_RESP: BVALID and BRESP held stable until BREADY. The handshake edge clears BVALID; readies rise the following cycle.
- Read path, states RD_IDLE and RD_RESP:
  - ARREADY = ARESETn & !RVALID.
  - An AR handshake loads RDATA and RRESP and sets RVALID on the same edge.
  - RDATA, RRESP and RVALID are held until RREADY. RDATA does not change while RVALID=1.
- Read and write channels are fully concurrent. If a read samples a register on the edge it is written, the read returns the old value.
- Out-of-range handling is set by the configuration macro below.

## Timing
- Reset (ARESETn=0 at an edge): all registers 0; BVALID, RVALID 0; BRESP, RRESP 2'b00; RDATA 0; aw_full, w_full 0.
- READY outputs are 0 while ARESETn=0 and 1 in the first cycle after release.
- Reset mid-transaction discards latched AW/W and any pending B or R response. No partial write occurs.
- Write latency: last of AW/W handshakes at edge k -> register and reg_out updated, BVALID=1, after edge k+1.
- Write throughput: with BREADY tied high, one write every 3 cycles.
- Read latency: AR handshake at edge k -> RVALID=1 with valid RDATA after edge k. With RREADY tied high, one read every 2 cycles.
- reg_out is registered; it reflects a write after the same edge that sets BVALID.

## Configuration
- AXIL_SLAVE_ERR_EN defined:
  - Out-of-range write: no register change, BRESP=2'b10 (SLVERR).
  - Out-of-range read: RDATA=32'h0, RRESP=2'b10.
  - In-range accesses respond 2'b00.
- AXIL_SLAVE_ERR_EN undefined:
  - No range check; the address aliases via the index bits only.
  - All responses are 2'b00.

## Test plan
- Reset, then write 32'hA5A5_5A5A to 32'h1111_1111 with AW and W in the same cycle and BREADY=1 -> BVALID one cycle later, BRESP=00, reg_out[159:128]=32'hA5A5_5A5A; read of the same address returns it with RRESP=00.
- W two cycles before AW, then AW; BREADY held low 3 cycles -> WREADY=0 after the W handshake; BVALID stays 1 and stable until BREADY; a single write occurs.
- Register 0 holds 32'hFFFF_FFFF; write 32'h1234_5678 with WSTRB=4'b0101 -> reg0=32'hFF34_FF78.
- Read of 32'h1111_1104 with RREADY low 4 cycles while a write to the same register completes -> RDATA keeps the pre-write value until the handshake; the next read returns the new value.
- Write and read to 32'h1111_1140:
  - with AXIL_SLAVE_ERR_EN -> BRESP=10, RRESP=10, RDATA=0, no register changes;
  - without it -> write lands in reg0, both responses 00.
- ARESETn pulsed low while aw_full=1 and RVALID=1 -> after release RVALID=0, all registers 0; a subsequent W alone produces no write.
